ball_sprite_gen: RTL and testbench
==================================

Name: ball_sprite_gen

Overview:
Upstream pixel source for vgaDriver. Owns one square "ball" sprite that moves a fixed step per frame and bounces off the visible-area edges. Takes the driver's current pixel position and vSync and produces the RGB565 word for that pixel. It replaces ad-hoc top-level ball logic with a single-clock block: edge-detected frame tick, synchronous reset, registered output.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in lines
BALL_SIZE, 8, sprite edge length in pixels
H_INIT, 128, ball x (left column) after reset
V_INIT, 128, ball y (top line) after reset
SPEED, 2, pixels moved per frame on each axis (1..BALL_SIZE)
FG_COLOR, 16'hFFFF, ball colour (RGB565)
BG_COLOR, 16'h0000, background colour inside the visible area

Ports:
clk_i  input  1  pixel clock, same clock as vgaDriver
reset_i  input  1  synchronous, active-high reset
enable_i  input  1  1 = motion enabled; 0 = ball frozen, rendering continues
vsync_i  input  1  vgaDriver vSync_o, active low
hpos_i  input  10  current pixel column from driver
vpos_i  input  10  current pixel line from driver
rgb_o  output  16  RGB565 pixel to driver rgb_i
ball_x_o  output  10  current ball left column
ball_y_o  output  10  current ball top line
frame_tick_o  output  1  one-cycle pulse per detected vSync start
bounce_o  output  2  one-cycle pulse with frame_tick_o; [0] x-axis bounce, [1] y-axis bounce

Behaviour:
- Reset (reset_i high on a clk_i edge): ball_x=H_INIT, ball_y=V_INIT, dx=-SPEED, dy=+SPEED, rgb_o=0, frame_tick_o=0, bounce_o=0, vsync_prev=0 (active level). Reset takes priority over all other activity, including mid-frame.
- Frame tick: vsync_prev <= vsync_i every cycle. frame_tick_o <= vsync_prev & ~vsync_i (falling edge = start of sync pulse). Pulse is registered and visible the cycle after the first low sample. Holding vsync low produces exactly one tick.
- Because vsync_prev resets to 0, vsync held low across reset release produces no tick until vsync rises and falls again.
- Motion: updated in the same cycle frame_tick_o is asserted, and only when enable_i=1 on that edge. If enable_i=0, ball_x/ball_y/dx/dy hold and bounce_o=0. frame_tick_o still pulses.
- Velocity dx, dy are signed 11-bit. nx = ball_x + dx is computed signed 12-bit with no wrap.
- X axis:
  - If nx <= 0: ball_x=0, dx=+SPEED, bounce_o[0]=1.
  - Else if nx >= H_RES-BALL_SIZE: ball_x=H_RES-BALL_SIZE, dx=-SPEED, bounce_o[0]=1.
  - Else ball_x=nx.
- Y axis: identical rules using V_RES and bounce_o[1]. Both axes are evaluated independently in the same cycle. A corner hit sets bounce_o=2'b11.
- bounce_o is 0 in every cycle without frame_tick_o.
- Positions change only at the sync start, which is inside vertical blanking, so no tearing occurs within a visible frame.
- Rendering: hit = (hpos_i >= ball_x) & (hpos_i < ball_x+BALL_SIZE) & (vpos_i >= ball_y) & (vpos_i < ball_y+BALL_SIZE).
- rgb_o is registered with 1-cycle latency:
  - 0 when hpos_i >= H_RES or vpos_i >= V_RES.
  - Else FG_COLOR when hit.
  - Else BG_COLOR.
  - hit is evaluated against the ball position held before the clock edge.
- ball_x_o/ball_y_o are direct register outputs.
- No combinational path from any input to any output.

Test Plan:
- Reset, then one vsync falling edge with enable_i=1 (defaults) -> frame_tick_o high 1 cycle; ball_x_o=126, ball_y_o=130; bounce_o=00.
- 64 ticks from reset (defaults) -> ball_x_o=0, bounce_o=01 on tick 64; tick 65 -> ball_x_o=2. ball_y_o=256 at tick 64.
- V_INIT=470, H_INIT=2: tick 1 -> ball_x_o=0, ball_y_o=472, bounce_o=11; tick 2 -> ball_x_o=2, ball_y_o=470.
- Ball at (126,130) -> rgb_o is FFFF one cycle after hpos=126,vpos=130 and after hpos=133,vpos=137. rgb_o=0000 after hpos=134,vpos=130 and after hpos=125,vpos=130. rgb_o=0 after hpos=700.
- enable_i=0 across 5 ticks -> 5 frame_tick_o pulses, position unchanged, bounce_o=00. vsync held low for 100 cycles -> exactly one tick.
- reset_i pulsed mid-frame after 10 ticks -> next cycle ball (128,128), rgb_o=0. With vsync low during reset release, no tick occurs until the next high-to-low transition.

Source files
------------

// File: rtl/ball_sprite_gen.sv
// ball_sprite_gen: bouncing square sprite pixel source for vgaDriver; ports: clk_i/reset_i (sync, active high), enable_i (motion), vsync_i (active low), hpos_i/vpos_i (pixel position) -> rgb_o (registered RGB565), ball_x_o/ball_y_o, frame_tick_o, bounce_o[1:0] (y,x)
module ball_sprite_gen #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int BALL_SIZE = 8,
  parameter int H_INIT = 128,
  parameter int V_INIT = 128,
  parameter int SPEED = 2,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        vsync_i,
  input  logic [9:0]  hpos_i,
  input  logic [9:0]  vpos_i,
  output logic [15:0] rgb_o,
  output logic [9:0]  ball_x_o,
  output logic [9:0]  ball_y_o,
  output logic        frame_tick_o,
  output logic [1:0]  bounce_o
);
  localparam logic signed [11:0] X_MAX = 12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX = 12'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] SP = 11'(SPEED);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  logic vsync_prev, tick, hit, visible, x_lo, x_hi, y_lo, y_hi;
  logic signed [10:0] dx, dy;
  logic signed [11:0] nx, ny;
  assign tick = vsync_prev & ~vsync_i;
  assign nx = $signed({2'b00, ball_x_o}) + $signed({dx[10], dx});
  assign ny = $signed({2'b00, ball_y_o}) + $signed({dy[10], dy});
  assign x_lo = nx <= 12'sd0;
  assign x_hi = nx >= X_MAX;
  assign y_lo = ny <= 12'sd0;
  assign y_hi = ny >= Y_MAX;
  assign visible = ({1'b0, hpos_i} < HR) & ({1'b0, vpos_i} < VR);
  assign hit = (hpos_i >= ball_x_o) & ({1'b0, hpos_i} < {1'b0, ball_x_o} + BS) &
               (vpos_i >= ball_y_o) & ({1'b0, vpos_i} < {1'b0, ball_y_o} + BS);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_prev <= 1'b0;
      frame_tick_o <= 1'b0;
      bounce_o <= 2'b00;
      rgb_o <= 16'h0000;
      ball_x_o <= 10'(H_INIT);
      ball_y_o <= 10'(V_INIT);
      dx <= -SP;
      dy <= SP;
    end else begin
      vsync_prev <= vsync_i;
      frame_tick_o <= tick;
      bounce_o <= 2'b00;
      rgb_o <= !visible ? 16'h0000 : hit ? FG_COLOR : BG_COLOR;
      if (tick && enable_i) begin
        ball_x_o <= x_lo ? 10'd0 : x_hi ? X_MAX[9:0] : nx[9:0];
        ball_y_o <= y_lo ? 10'd0 : y_hi ? Y_MAX[9:0] : ny[9:0];
        dx <= x_lo ? SP : x_hi ? -SP : dx;
        dy <= y_lo ? SP : y_hi ? -SP : dy;
        bounce_o <= {y_lo | y_hi, x_lo | x_hi};
      end
    end
  end
endmodule

// File: tb/tb_ball_sprite_gen.sv
// tb_ball_sprite_gen: randomized and directed bench for ball_sprite_gen against a behavioural model
module tb_ball_sprite_gen;
  logic clk = 0, reset = 1, en = 1, vsync = 1;
  logic [9:0] hpos = 0, vpos = 0;
  logic [15:0] rgb [2];
  logic [9:0] bx [2], by [2];
  logic tk [2];
  logic [1:0] bn [2];
  int n_chk = 0, n_err = 0, tick_cnt = 0;
  int hi [2] = '{128, 2};
  int vi [2] = '{128, 470};
  int mx [2], my [2], mdx [2], mdy [2], mrgb [2], mtk [2], mb [2], mprev [2];
  always #5 clk = ~clk;
  ball_sprite_gen dut0 (.clk_i(clk), .reset_i(reset), .enable_i(en), .vsync_i(vsync),
    .hpos_i(hpos), .vpos_i(vpos), .rgb_o(rgb[0]), .ball_x_o(bx[0]), .ball_y_o(by[0]),
    .frame_tick_o(tk[0]), .bounce_o(bn[0]));
  ball_sprite_gen #(.H_INIT(2), .V_INIT(470)) dut1 (.clk_i(clk), .reset_i(reset), .enable_i(en),
    .vsync_i(vsync), .hpos_i(hpos), .vpos_i(vpos), .rgb_o(rgb[1]), .ball_x_o(bx[1]),
    .ball_y_o(by[1]), .frame_tick_o(tk[1]), .bounce_o(bn[1]));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int t, nx, ny, b;
      if (reset) begin
        mx[k] = hi[k]; my[k] = vi[k]; mdx[k] = -2; mdy[k] = 2;
        mrgb[k] = 0; mtk[k] = 0; mb[k] = 0; mprev[k] = 0;
      end else begin
        t = (mprev[k] == 1 && vsync == 0) ? 1 : 0;
        if (hpos >= 640 || vpos >= 480) mrgb[k] = 0;
        else if (hpos >= mx[k] && hpos < mx[k] + 8 && vpos >= my[k] && vpos < my[k] + 8) mrgb[k] = 'hFFFF;
        else mrgb[k] = 0;
        b = 0;
        if (t == 1 && en) begin
          nx = mx[k] + mdx[k];
          ny = my[k] + mdy[k];
          if (nx <= 0) begin mx[k] = 0; mdx[k] = 2; b += 1; end
          else if (nx >= 632) begin mx[k] = 632; mdx[k] = -2; b += 1; end
          else mx[k] = nx;
          if (ny <= 0) begin my[k] = 0; mdy[k] = 2; b += 2; end
          else if (ny >= 472) begin my[k] = 472; mdy[k] = -2; b += 2; end
          else my[k] = ny;
        end
        mprev[k] = vsync;
        mtk[k] = t;
        mb[k] = b;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (tk[0]) tick_cnt++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rgb%0d", k), rgb[k], mrgb[k]);
      chk($sformatf("x%0d", k), bx[k], mx[k]);
      chk($sformatf("y%0d", k), by[k], my[k]);
      chk($sformatf("tick%0d", k), tk[k], mtk[k]);
      chk($sformatf("bounce%0d", k), bn[k], mb[k]);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) step();
  endtask
  task automatic frame();
    vsync = 1; cyc(2);
    vsync = 0; cyc(1);
  endtask
  task automatic pix(input int h, input int v, input int exp, input string tag);
    hpos = 10'(h); vpos = 10'(v); cyc(1);
    chk(tag, rgb[0], exp);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0; mrgb[k] = 0; mtk[k] = 0; mb[k] = 0; mprev[k] = 0;
    end
    hpos = 700; vpos = 0;
    cyc(2);
    reset = 0;
    cyc(1);
    chk("rst_x", bx[0], 128); chk("rst_y", by[0], 128); chk("rst_rgb", rgb[0], 0);
    frame();
    chk("t1_tick", tk[0], 1); chk("t1_x", bx[0], 126); chk("t1_y", by[0], 130); chk("t1_b", bn[0], 0);
    chk("d1_x", bx[1], 0); chk("d1_y", by[1], 472); chk("d1_b", bn[1], 3);
    cyc(1);
    chk("t1_pulse", tk[0], 0);
    pix(126, 130, 'hFFFF, "px_tl");
    pix(133, 137, 'hFFFF, "px_br");
    pix(134, 130, 0, "px_right");
    pix(125, 130, 0, "px_left");
    pix(700, 130, 0, "px_offscreen");
    frame();
    chk("d2_x", bx[1], 2); chk("d2_y", by[1], 470);
    for (int i = 3; i <= 64; i++) frame();
    chk("t64_x", bx[0], 0); chk("t64_y", by[0], 256); chk("t64_b", bn[0], 1);
    frame();
    chk("t65_x", bx[0], 2);
    en = 0;
    tick_cnt = 0;
    repeat (5) frame();
    chk("dis_ticks", tick_cnt, 5); chk("dis_x", bx[0], 2); chk("dis_b", bn[0], 0);
    en = 1;
    vsync = 1; cyc(2);
    tick_cnt = 0;
    vsync = 0; cyc(100);
    chk("hold_ticks", tick_cnt, 1);
    repeat (10) frame();
    hpos = 300; vpos = 200;
    reset = 1; cyc(1);
    chk("mid_rst_x", bx[0], 128); chk("mid_rst_y", by[0], 128); chk("mid_rst_rgb", rgb[0], 0);
    vsync = 0; cyc(1);
    reset = 0;
    tick_cnt = 0;
    cyc(5);
    chk("rel_no_tick", tick_cnt, 0);
    vsync = 1; cyc(1); vsync = 0; cyc(1);
    chk("rel_tick", tk[0], 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      en = $urandom_range(0, 9) != 0;
      reset = $urandom_range(0, 799) == 0;
      if ($urandom_range(0, 1) == 1) begin
        hpos = 10'(mx[0] + $urandom_range(0, 12) - 2);
        vpos = 10'(my[0] + $urandom_range(0, 12) - 2);
      end else begin
        hpos = 10'($urandom_range(0, 1023));
        vpos = 10'($urandom_range(0, 1023));
      end
      cyc(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
